sdr_ram_resp: RTL

SDR_RAM_RESP -- requirements
Module: sdr_ram_resp

---
 rtl/sdr_pkg.sv | 67 ++++++
 rtl/sdr_rd_pipe.sv | 51 +++++
 rtl/sdr_ram_resp.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sdr_pkg.sv
//------------------------------------------------------------------------------
// Module : sdr_pkg
// Brief  : Shared command encodings, bank states, error codes and mode decode
//          helpers for the SDR SDRAM responder model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sdr_pkg;

  // {ras_n, cas_n, we_n} with cs_n low; deselect is folded onto NOP
  typedef enum logic [3:0] {
    CMD_LOAD_MODE    = 4'b0000,
    CMD_AUTO_REFRESH = 4'b0001,
    CMD_PRECHARGE    = 4'b0010,
    CMD_ACTIVE       = 4'b0011,
    CMD_WRITE        = 4'b0100,
    CMD_READ         = 4'b0101,
    CMD_BURST_TERM   = 4'b0110,
    CMD_NOP          = 4'b0111
  } sdr_cmd_e;

  typedef enum logic [2:0] {
    BANK_IDLE = 3'b000,
    BANK_ACT  = 3'b010,
    BANK_XFR  = 3'b011
  } bank_st_e;

  localparam logic [2:0] ERR_NONE     = 3'b000;
  localparam logic [2:0] ERR_ACT_OPEN = 3'b001;
  localparam logic [2:0] ERR_NOT_OPEN = 3'b010;
  localparam logic [2:0] ERR_REFRESH  = 3'b100;
  localparam logic [2:0] ERR_MODE     = 3'b101;

  localparam logic [2:0] BL_CODE_1 = 3'b000;
  localparam logic [2:0] BL_CODE_2 = 3'b001;
  localparam logic [2:0] BL_CODE_4 = 3'b010;
  localparam logic [2:0] BL_CODE_8 = 3'b011;
  localparam logic [2:0] CL_CODE_2 = 3'b010;
  localparam logic [2:0] CL_CODE_3 = 3'b011;

  localparam logic [3:0] BL_RESET = 4'd1;
  localparam logic [1:0] CL_RESET = 2'd2;

  // Returns burst length in words, or 0 for an unsupported code
  function automatic logic [3:0] bl_decode(input logic [2:0] code);
    case (code)
      BL_CODE_1: return 4'd1;
      BL_CODE_2: return 4'd2;
      BL_CODE_4: return 4'd4;
      BL_CODE_8: return 4'd8;
      default:   return 4'd0;
    endcase
  endfunction

  // Returns CAS latency in cycles, or 0 for an unsupported code
  function automatic logic [1:0] cl_decode(input logic [2:0] code);
    case (code)
      CL_CODE_2: return 2'd2;
      CL_CODE_3: return 2'd3;
      default:   return 2'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdr_rd_pipe.sv
//------------------------------------------------------------------------------
// Module : sdr_rd_pipe
// Brief  : CAS-latency delay line for read data; output is registered so a
//          word pushed on edge n appears after edge n+CL.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sdr_rd_pipe #(
  parameter int DW    = 16,
  parameter int DEPTH = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [1:0]    cl_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] dq_o,
  output logic          oe_o
);

  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DW-1:0]    dq_q;
  logic             oe_q;
  logic [1:0]       tap;

  assign tap = cl_i - 2'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      dq_q  <= '0;
      oe_q  <= 1'b0;
    end else if (en_i) begin
      vld_q     <= {vld_q[DEPTH-2:0], push_i};
      data_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
      oe_q      <= vld_q[tap];
      dq_q      <= vld_q[tap] ? data_q[tap] : '0;
    end
  end

  assign dq_o = dq_q;
  assign oe_o = oe_q;

endmodule

`default_nettype wire

// File: rtl/sdr_ram_resp.sv
//------------------------------------------------------------------------------
// Module : sdr_ram_resp
// Brief  : Behavioural SDR SDRAM responder: command decode, per-bank state,
//          burst sequencing, byte-masked storage and protocol error reporting.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sdr_ram_resp
  import sdr_pkg::*;
#(
  parameter int SDR_DW = 16,
  parameter int SDR_BW = 2,
  parameter int MEM_AW = 10
) (
  input  logic              sdram_clk_d,
  input  logic              sdram_reset,
  input  logic              sdr_cke,
  input  logic              sdr_cs_n,
  input  logic              sdr_ras_n,
  input  logic              sdr_cas_n,
  input  logic              sdr_we_n,
  input  logic [1:0]        sdr_ba,
  input  logic [12:0]       sdr_addr,
  input  logic [SDR_BW-1:0] sdr_dqm,
  input  logic [SDR_DW-1:0] sdr_dq_in,
  output logic [SDR_DW-1:0] sdr_dq_out,
  output logic              sdr_dq_oe,
  output logic [3:0][2:0]   bank_st,
  output logic              err_valid,
  output logic [2:0]        err_code
);

  localparam int CW    = MEM_AW - 4;
  localparam int DEPTH = 1 << MEM_AW;

  logic [SDR_DW-1:0] mem_q [DEPTH];

  bank_st_e    bank_q [4];
  bank_st_e    bank_d [4];
  logic [1:0]  row_q  [4];
  logic [1:0]  row_d  [4];
  logic [3:0]  bl_q, bl_d;
  logic [1:0]  cl_q, cl_d;
  logic        burst_q, burst_d;
  logic        burst_wr_q, burst_wr_d;
  logic [1:0]  burst_ba_q, burst_ba_d;
  logic [CW-1:0] burst_col_q, burst_col_d;
  logic [2:0]  burst_cnt_q, burst_cnt_d;
  logic        err_valid_q, err_valid_d;
  logic [2:0]  err_code_q, err_code_d;

  sdr_cmd_e      cmd;
  logic          any_open;
  logic          start, stop;
  logic [3:0]    mode_bl;
  logic [1:0]    mode_cl;
  logic [CW-1:0] wrap_mask, next_col;
  logic          xfer_en, xfer_wr;
  logic [1:0]    xfer_ba;
  logic [CW-1:0] xfer_col;
  logic [MEM_AW-1:0] mem_idx;
  logic          rd_push;
  logic [SDR_DW-1:0] rd_data;
  logic          unused_addr;

  assign unused_addr = ^sdr_addr;

  always_comb begin
    cmd = CMD_NOP;
    if (!sdr_cs_n) cmd = sdr_cmd_e'({1'b0, sdr_ras_n, sdr_cas_n, sdr_we_n});
  end

  always_comb begin
    any_open = 1'b0;
    for (int b = 0; b < 4; b++) if (bank_q[b] != BANK_IDLE) any_open = 1'b1;
  end

  assign mode_bl = bl_decode(sdr_addr[2:0]);
  assign mode_cl = cl_decode(sdr_addr[6:4]);

  // Sequential column within the BL-aligned block
  assign wrap_mask = CW'(bl_q - 4'd1);
  assign next_col  = (burst_col_q & ~wrap_mask) |
                     ((burst_col_q + CW'(burst_cnt_q)) & wrap_mask);

  always_comb begin
    bank_d      = bank_q;
    row_d       = row_q;
    bl_d        = bl_q;
    cl_d        = cl_q;
    burst_d     = burst_q;
    burst_wr_d  = burst_wr_q;
    burst_ba_d  = burst_ba_q;
    burst_col_d = burst_col_q;
    burst_cnt_d = burst_cnt_q;
    err_valid_d = 1'b0;
    err_code_d  = ERR_NONE;
    start       = 1'b0;
    stop        = 1'b0;
    xfer_en     = 1'b0;
    xfer_wr     = burst_wr_q;
    xfer_ba     = burst_ba_q;
    xfer_col    = next_col;

    if (sdr_cke) begin
      case (cmd)
        CMD_ACTIVE: begin
          if (bank_q[sdr_ba] != BANK_IDLE) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_ACT_OPEN;
          end else begin
            bank_d[sdr_ba] = BANK_ACT;
            row_d[sdr_ba]  = sdr_addr[1:0];
          end
        end
        CMD_READ, CMD_WRITE: begin
          if (bank_q[sdr_ba] == BANK_IDLE) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_NOT_OPEN;
          end else begin
            start = 1'b1;
          end
        end
        CMD_BURST_TERM: stop = 1'b1;
        CMD_PRECHARGE: begin
          if (sdr_addr[10]) begin
            for (int b = 0; b < 4; b++) bank_d[b] = BANK_IDLE;
            stop = 1'b1;
          end else begin
            bank_d[sdr_ba] = BANK_IDLE;
            if (sdr_ba == burst_ba_q) stop = 1'b1;
          end
        end
        CMD_AUTO_REFRESH: begin
          if (any_open) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_REFRESH;
          end
        end
        CMD_LOAD_MODE: begin
          if (any_open || mode_bl == 4'd0 || mode_cl == 2'd0) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_MODE;
          end else begin
            bl_d = mode_bl;
            cl_d = mode_cl;
          end
        end
        default: ;
      endcase

      // Old burst either yields to a new command or addresses its next word
      if (burst_q) begin
        if (start || stop) begin
          burst_d = 1'b0;
          if (bank_d[burst_ba_q] == BANK_XFR) bank_d[burst_ba_q] = BANK_ACT;
        end else begin
          xfer_en     = 1'b1;
          burst_cnt_d = burst_cnt_q + 3'd1;
          if ({1'b0, burst_cnt_q} + 4'd1 == bl_q) begin
            burst_d = 1'b0;
            if (bank_d[burst_ba_q] == BANK_XFR) bank_d[burst_ba_q] = BANK_ACT;
          end
        end
      end

      if (start) begin
        xfer_en     = 1'b1;
        xfer_wr     = (cmd == CMD_WRITE);
        xfer_ba     = sdr_ba;
        xfer_col    = sdr_addr[CW-1:0];
        burst_wr_d  = (cmd == CMD_WRITE);
        burst_ba_d  = sdr_ba;
        burst_col_d = sdr_addr[CW-1:0];
        burst_cnt_d = 3'd1;
        if (bl_q != 4'd1) begin
          burst_d        = 1'b1;
          bank_d[sdr_ba] = BANK_XFR;
        end
      end
    end
  end

  always_ff @(posedge sdram_clk_d or posedge sdram_reset) begin
    if (sdram_reset) begin
      for (int b = 0; b < 4; b++) begin
        bank_q[b] <= BANK_IDLE;
        row_q[b]  <= '0;
      end
      bl_q        <= BL_RESET;
      cl_q        <= CL_RESET;
      burst_q     <= 1'b0;
      burst_wr_q  <= 1'b0;
      burst_ba_q  <= '0;
      burst_col_q <= '0;
      burst_cnt_q <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      bank_q      <= bank_d;
      row_q       <= row_d;
      bl_q        <= bl_d;
      cl_q        <= cl_d;
      burst_q     <= burst_d;
      burst_wr_q  <= burst_wr_d;
      burst_ba_q  <= burst_ba_d;
      burst_col_q <= burst_col_d;
      burst_cnt_q <= burst_cnt_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign mem_idx = {xfer_ba, row_q[xfer_ba], xfer_col};

  // Storage deliberately has no reset so contents survive sdram_reset
  always_ff @(posedge sdram_clk_d) begin
    if (xfer_en && xfer_wr && !sdram_reset) begin
      for (int i = 0; i < SDR_BW; i++)
        if (!sdr_dqm[i]) mem_q[mem_idx][i*8 +: 8] <= sdr_dq_in[i*8 +: 8];
    end
  end

  assign rd_push = xfer_en && !xfer_wr;
  assign rd_data = mem_q[mem_idx];

  sdr_rd_pipe #(
    .DW    (SDR_DW),
    .DEPTH (3)
  ) u_rd_pipe (
    .clk_i  (sdram_clk_d),
    .rst_i  (sdram_reset),
    .en_i   (sdr_cke),
    .cl_i   (cl_q),
    .push_i (rd_push),
    .data_i (rd_data),
    .dq_o   (sdr_dq_out),
    .oe_o   (sdr_dq_oe)
  );

  generate
    for (genvar b = 0; b < 4; b++) begin : g_bank_st
      assign bank_st[b] = bank_q[b];
    end
  endgenerate

  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

endmodule

`default_nettype wire
